// File: rtl/shared_buf_arbiter_if.sv
// Bundle between N write requesters, one reader and the shared syn_fifo.
// slave is the arbiter view; master is the requester/FIFO environment view.
interface shared_buf_arbiter_if #(
    parameter int unsigned N_PORTS = 4,
    parameter int unsigned DATA_W  = 4,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned LVL_W   = $clog2(DEPTH) + 1
);
    logic [N_PORTS-1:0]        wr_req;
    logic [N_PORTS*DATA_W-1:0] wr_data;
    logic [N_PORTS-1:0]        wr_ack;
    logic                      rd_req;
    logic                      rd_ack;
    logic                      rd_valid;
    logic [DATA_W-1:0]         rd_data;
    logic                      fifo_wr_en;
    logic [DATA_W-1:0]         fifo_data_in;
    logic                      fifo_full;
    logic                      fifo_rd_en;
    logic [DATA_W-1:0]         fifo_data_out;
    logic                      fifo_empty;
    logic [N_PORTS-1:0]        gnt;
    logic [LVL_W-1:0]          level;
    logic                      almost_full;
    logic                      ovf_err;

    modport slave (
        input  wr_req, wr_data, rd_req, fifo_full, fifo_data_out, fifo_empty,
        output wr_ack, rd_ack, rd_valid, rd_data, fifo_wr_en, fifo_data_in, fifo_rd_en,
               gnt, level, almost_full, ovf_err
    );

    modport master (
        output wr_req, wr_data, rd_req, fifo_full, fifo_data_out, fifo_empty,
        input  wr_ack, rd_ack, rd_valid, rd_data, fifo_wr_en, fifo_data_in, fifo_rd_en,
               gnt, level, almost_full, ovf_err
    );
endinterface

// File: rtl/shared_buf_arbiter.sv
// Round-robin burst arbiter sharing one syn_fifo among N_PORTS writers, with a
// req/valid read wrapper and occupancy / almost-full / overflow tracking.
module shared_buf_arbiter #(
    parameter int unsigned N_PORTS   = 4,
    parameter int unsigned DATA_W    = 4,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned AF_MARGIN = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    shared_buf_arbiter_if.slave bus
);
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;
    localparam int unsigned PTR_W = $clog2(N_PORTS);
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StBurst = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [PTR_W-1:0]  gnt_idx_q, gnt_idx_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              ovf_q, ovf_d;

    logic              wr_en;
    logic              rd_en;
    logic              pick_found;
    logic [PTR_W-1:0]  pick_idx;
    logic [PTR_W-1:0]  rr_next;

    // First requester at or after rr_ptr, scanning cyclically.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = rr_ptr_q;
        for (int unsigned k = 0; k < N_PORTS; k++) begin
            if (!pick_found && bus.wr_req[(32'(rr_ptr_q) + k) % N_PORTS]) begin
                pick_found = 1'b1;
                pick_idx   = PTR_W'((32'(rr_ptr_q) + k) % N_PORTS);
            end
        end
    end

    always_comb begin
        wr_en = (state_q == StBurst) && bus.wr_req[gnt_idx_q] && !bus.fifo_full;
        rd_en = bus.rd_req && !bus.fifo_empty;
        rr_next = (gnt_idx_q == PTR_W'(N_PORTS - 1)) ? '0 : gnt_idx_q + PTR_W'(1);

        bus.gnt          = (state_q == StBurst) ? (N_PORTS'(1) << gnt_idx_q) : '0;
        bus.wr_ack       = wr_en ? bus.gnt : '0;
        bus.fifo_wr_en   = wr_en;
        bus.fifo_data_in = (state_q == StBurst) ? bus.wr_data[gnt_idx_q*DATA_W +: DATA_W] : '0;
        bus.fifo_rd_en   = rd_en;
        bus.rd_ack       = rd_en;
        bus.rd_valid     = rd_valid_q;
        // syn_fifo already registers data_out on rd_en, so pass it through while valid
        // and hold the last word afterwards.
        bus.rd_data      = rd_valid_q ? bus.fifo_data_out : rd_data_q;
        bus.level        = level_q;
        bus.almost_full  = level_q >= LVL_W'(DEPTH - AF_MARGIN);
        bus.ovf_err      = ovf_q;
    end

    always_comb begin
        state_d     = state_q;
        gnt_idx_d   = gnt_idx_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            StIdle: begin
                if (pick_found) begin
                    state_d     = StBurst;
                    gnt_idx_d   = pick_idx;
                    burst_cnt_d = '0;
                end
            end
            default: begin
                // A full FIFO only stalls; rotation happens on release or burst limit.
                if (!bus.wr_req[gnt_idx_q] ||
                    (wr_en && burst_cnt_q == CNT_W'(MAX_BURST - 1))) begin
                    state_d  = StIdle;
                    rr_ptr_d = rr_next;
                end else if (wr_en) begin
                    burst_cnt_d = burst_cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    always_comb begin
        level_d    = level_q;
        ovf_d      = ovf_q;
        rd_valid_d = rd_en;
        rd_data_d  = rd_valid_q ? bus.fifo_data_out : rd_data_q;
        if (wr_en && !rd_en && level_q != LVL_W'(DEPTH)) begin
            level_d = level_q + LVL_W'(1);
        end else if (rd_en && !wr_en && level_q != '0) begin
            level_d = level_q - LVL_W'(1);
        end
        if ((wr_en && !rd_en && level_q == LVL_W'(DEPTH)) || (rd_en && level_q == '0)) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            gnt_idx_q   <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            level_q     <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_idx_q   <= gnt_idx_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            level_q     <= level_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            ovf_q       <= ovf_d;
        end
    end
endmodule
